// File: rtl/toy_phy_freelist.sv
`default_nettype none
// ============================================================================
// Module   : toy_phy_freelist
// Brief    : Physical-register free list for one register class. Offers up to
//            ALLOC_NUM free IDs per cycle to the rename lanes and reclaims up
//            to REL_NUM committed IDs per cycle. A cancel restores the
//            committed free set in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module toy_phy_freelist #(
  parameter int MODE      = 0,
  parameter int PHY_NUM   = 64,
  parameter int ARCH_NUM  = 32,
  parameter int DEPTH     = PHY_NUM - ARCH_NUM,
  parameter int ALLOC_NUM = 4,
  parameter int REL_NUM   = 4,
  parameter int ID_W      = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ALLOC_NUM-1:0]           v_alloc_zero,
  input  logic [ALLOC_NUM-1:0]           v_alloc_rdy,
  output logic [ALLOC_NUM-1:0]           v_alloc_vld,
  output logic [ALLOC_NUM-1:0][ID_W-1:0] v_alloc_id,
  input  logic                           cancel_edge_en,
  input  logic [REL_NUM-1:0]             v_release_en,
  input  logic [REL_NUM-1:0][ID_W-1:0]   v_release_id,
  output logic [ID_W-1:0]                free_cnt,
  output logic                           overflow_err
);

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [ID_W-1:0]    fifo_q [DEPTH];
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [c_cnt_w-1:0] w_nz;
  logic [c_cnt_w-1:0] w_pop;
  logic [c_cnt_w-1:0] w_req_cnt;
  logic [c_cnt_w-1:0] w_room;
  logic [c_cnt_w-1:0] w_push;
  logic [c_cnt_w-1:0] w_slot [REL_NUM];
  logic [REL_NUM-1:0] w_req;
  logic [REL_NUM-1:0] w_wr_en;
  logic               w_ovf;

  // Offer IDs to lanes from registered state only; x0 lanes skip the FIFO.
  always_comb begin
    w_nz        = '0;
    w_pop       = '0;
    v_alloc_vld = '0;
    v_alloc_id  = '0;
    for (int i = 0; i < ALLOC_NUM; i++) begin
      if (v_alloc_zero[i]) begin
        v_alloc_vld[i] = 1'b1;
      end else begin
        v_alloc_vld[i] = (w_nz < cnt_q);
        v_alloc_id[i]  = fifo_q[rd_ptr_q + c_ptr_w'(w_nz)];
        // A flush discards this cycle's allocations, so nothing is popped.
        if (v_alloc_vld[i] && v_alloc_rdy[i] && !cancel_edge_en) begin
          w_pop = w_pop + c_one;
        end
        w_nz = w_nz + c_one;
      end
    end
  end

  // Compact non-zero releases and clip them to the room left after popping.
  always_comb begin
    w_req_cnt = '0;
    w_req     = '0;
    w_wr_en   = '0;
    for (int j = 0; j < REL_NUM; j++) begin
      w_slot[j] = w_req_cnt;
      if (v_release_en[j] && (v_release_id[j] != '0)) begin
        w_req[j]  = 1'b1;
        w_req_cnt = w_req_cnt + c_one;
      end
    end
    w_room = c_depth - cnt_q + w_pop;
    for (int j = 0; j < REL_NUM; j++) begin
      w_wr_en[j] = w_req[j] && (w_slot[j] < w_room);
    end
    w_ovf  = (w_req_cnt > w_room);
    w_push = w_ovf ? w_room : w_req_cnt;
  end

  // Next pointers/count; a cancel snaps the read side to the committed tail.
  always_comb begin
    wr_ptr_d = wr_ptr_q + c_ptr_w'(w_push);
    ovf_d    = w_ovf;
    if (cancel_edge_en) begin
      rd_ptr_d = wr_ptr_d;
      cnt_d    = c_depth;
    end else begin
      rd_ptr_d = rd_ptr_q + c_ptr_w'(w_pop);
      cnt_d    = cnt_q - w_pop + w_push;
    end
  end

  // State update; reset refills the list with the IDs above the arch range.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= c_depth;
      ovf_q    <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        fifo_q[k] <= ID_W'(ARCH_NUM + k);
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      for (int j = 0; j < REL_NUM; j++) begin
        if (w_wr_en[j]) begin
          fifo_q[wr_ptr_q + c_ptr_w'(w_slot[j])] <= v_release_id[j];
        end
      end
    end
  end

  // Both classes share the datapath; the branch only names the hierarchy.
  if (MODE == 0) begin : g_int
    assign free_cnt = ID_W'(cnt_q);
  end else begin : g_float
    assign free_cnt = ID_W'(cnt_q);
  end

  assign overflow_err = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_toy_phy_freelist.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_toy_phy_freelist
// Brief    : Directed vector table plus scoreboarded random traffic for the
//            physical-register free list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toy_phy_freelist;

  localparam int c_an    = 4;
  localparam int c_rn    = 4;
  localparam int c_iw    = 6;
  localparam int c_depth = 32;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [c_an-1:0]           v_alloc_zero = '0;
  logic [c_an-1:0]           v_alloc_rdy = '0;
  logic [c_an-1:0]           v_alloc_vld;
  logic [c_an-1:0][c_iw-1:0] v_alloc_id;
  logic                      cancel_edge_en = 1'b0;
  logic [c_rn-1:0]           v_release_en = '0;
  logic [c_rn-1:0][c_iw-1:0] v_release_id = '0;
  logic [c_iw-1:0]           free_cnt;
  logic                      overflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  toy_phy_freelist #(
    .MODE(0), .PHY_NUM(64), .ARCH_NUM(32), .DEPTH(32),
    .ALLOC_NUM(c_an), .REL_NUM(c_rn), .ID_W(c_iw)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .v_alloc_zero   (v_alloc_zero),
    .v_alloc_rdy    (v_alloc_rdy),
    .v_alloc_vld    (v_alloc_vld),
    .v_alloc_id     (v_alloc_id),
    .cancel_edge_en (cancel_edge_en),
    .v_release_en   (v_release_en),
    .v_release_id   (v_release_id),
    .free_cnt       (free_cnt),
    .overflow_err   (overflow_err)
  );

  // Upstream contract: ready lanes form a prefix starting at lane 0.
  always @(posedge clk) begin
    if (rst_n) begin
      assert ((v_alloc_rdy & (v_alloc_rdy + 4'd1)) == 4'd0)
        else $error("v_alloc_rdy not prefix-contiguous: %b", v_alloc_rdy);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [3:0]  zero;
    logic [3:0]  rdy;
    logic        cancel;
    logic [3:0]  rel_en;
    logic [23:0] rel_ids;
    logic [3:0]  vld;
    logic [23:0] ids;
    int          cnt;
    logic        ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [23:0] L(int a, int b, int c, int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  task automatic add(input logic rst, input logic [3:0] zero, input logic [3:0] rdy,
                     input logic cancel, input logic [3:0] en, input logic [23:0] rids,
                     input logic [3:0] vld, input logic [23:0] ids, input int cnt,
                     input logic ovf);
    vec_t v;
    v.rst = rst; v.zero = zero; v.rdy = rdy; v.cancel = cancel;
    v.rel_en = en; v.rel_ids = rids; v.vld = vld; v.ids = ids;
    v.cnt = cnt; v.ovf = ovf;
    tbl.push_back(v);
  endtask

  task automatic add_rst();
    add(1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 24'd0, 4'b0, 24'd0, 0, 1'b0);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int         freeq[$];
  int         outq[$];
  int         fired[$];
  logic       m_ovf;

  task automatic model_reset();
    freeq.delete();
    outq.delete();
    for (int k = 0; k < c_depth; k++) freeq.push_back(32 + k);
    m_ovf = 1'b0;
  endtask

  initial begin
    // ---------------- directed table ----------------
    add_rst(); add_rst();
    // reset state and x0 lane handling
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 24'd0, 4'b1111, L(32,33,34,35), 32, 0);
    add(0, 4'b0010, 4'b1111, 0, 4'b0000, 24'd0, 4'b1111, L(32,0,33,34),  32, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 24'd0, 4'b1111, L(35,36,37,38), 29, 0);
    // drain to empty, then release into the empty list
    add_rst();
    for (int k = 0; k < 8; k++)
      add(0, 4'b0000, 4'b1111, 0, 4'b0000, 24'd0, 4'b1111,
          L(32+4*k, 33+4*k, 34+4*k, 35+4*k), 32-4*k, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0011, L(40,50,0,0), 4'b0000, 24'd0, 0, 0);
    add(0, 4'b1000, 4'b0000, 0, 4'b0000, 24'd0, 4'b1011, L(40,50,0,0), 2, 0);
    add(0, 4'b0000, 4'b1111, 0, 4'b0001, L(60,0,0,0), 4'b0011, L(40,50,0,0), 2, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 24'd0, 4'b0001, L(60,0,0,0), 1, 0);
    // overflow: two releases with room for one
    add_rst();
    add(0, 4'b0000, 4'b0001, 0, 4'b0000, 24'd0, 4'b1111, L(32,33,34,35), 32, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0101, L(7,0,9,0), 4'b1111, L(33,34,35,36), 31, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 24'd0, 4'b1111, L(33,34,35,36), 32, 1);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 24'd0, 4'b1111, L(33,34,35,36), 32, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 24'd0, 4'b1111, L(33,34,35,36), 32, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 24'd0, 4'b1111, L(33,34,35,36), 32, 0);
    // cancel: allocate 12, release 5 (one of them ID 0), cancel, drain all
    add_rst();
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 24'd0, 4'b1111, L(32,33,34,35), 32, 0);
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 24'd0, 4'b1111, L(36,37,38,39), 28, 0);
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 24'd0, 4'b1111, L(40,41,42,43), 24, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b1111, L(5,0,17,3), 4'b1111, L(44,45,46,47), 20, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0001, L(21,0,0,0), 4'b1111, L(44,45,46,47), 23, 0);
    add(0, 4'b0000, 4'b1111, 1, 4'b0001, L(9,0,0,0),  4'b1111, L(44,45,46,47), 24, 0);
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 24'd0, 4'b1111, L(37,38,39,40), 32, 0);
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 24'd0, 4'b1111, L(41,42,43,44), 28, 0);
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 24'd0, 4'b1111, L(45,46,47,48), 24, 0);
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 24'd0, 4'b1111, L(49,50,51,52), 20, 0);
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 24'd0, 4'b1111, L(53,54,55,56), 16, 0);
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 24'd0, 4'b1111, L(57,58,59,60), 12, 0);
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 24'd0, 4'b1111, L(61,62,63,5),  8,  0);
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 24'd0, 4'b1111, L(17,3,21,9),   4,  0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 24'd0, 4'b0000, 24'd0, 0, 0);

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      rst_n          = ~tbl[r].rst;
      v_alloc_zero   = tbl[r].zero;
      v_alloc_rdy    = tbl[r].rdy;
      cancel_edge_en = tbl[r].cancel;
      v_release_en   = tbl[r].rel_en;
      v_release_id   = tbl[r].rel_ids;
      #1;
      if (!tbl[r].rst) begin
        check($sformatf("row%0d vld", r), int'(v_alloc_vld), int'(tbl[r].vld));
        for (int l = 0; l < c_an; l++) begin
          if (tbl[r].vld[l])
            check($sformatf("row%0d lane%0d id", r, l),
                  int'(v_alloc_id[l]), int'(tbl[r].ids[l*6 +: 6]));
        end
        check($sformatf("row%0d free_cnt", r), int'(free_cnt), tbl[r].cnt);
        check($sformatf("row%0d overflow_err", r), int'(overflow_err), int'(tbl[r].ovf));
      end
    end

    // ---------------- random traffic with scoreboard ----------------
    model_reset();
    for (int c = 0; c < 450; c++) begin
      logic                      do_rst;
      logic [3:0]                zr, rd, en, ev;
      logic [c_rn-1:0][c_iw-1:0] rid;
      logic [c_an-1:0][c_iw-1:0] eid;
      logic                      ok, ovf_n;
      int                        off, nrdy, idx;

      @(negedge clk);
      do_rst = (c == 0) || (c == 200) || (c == 201);
      zr     = 4'($urandom);
      nrdy   = $urandom_range(0, 4);
      rd     = 4'((5'd1 << nrdy) - 5'd1);
      en     = '0;
      rid    = '0;
      for (int ch = 0; ch < c_rn; ch++) begin
        if ($urandom_range(0, 1) == 1 && outq.size() > 0) begin
          idx = $urandom_range(0, outq.size() - 1);
          rid[ch] = 6'(outq[idx]);
          outq.delete(idx);
          en[ch] = 1'b1;
        end else if ($urandom_range(0, 7) == 0) begin
          en[ch] = 1'b1;
        end
      end
      rst_n          = ~do_rst;
      v_alloc_zero   = zr;
      v_alloc_rdy    = rd;
      cancel_edge_en = 1'b0;
      v_release_en   = en;
      v_release_id   = rid;

      off = 0;
      ev  = '0;
      eid = '0;
      for (int l = 0; l < c_an; l++) begin
        if (zr[l]) begin
          ev[l] = 1'b1;
        end else begin
          ev[l] = (off < freeq.size());
          if (ev[l]) eid[l] = 6'(freeq[off]);
          off++;
        end
      end
      #1;
      if (c != 0) begin
        ok = (v_alloc_vld === ev) && (int'(free_cnt) == freeq.size()) &&
             (overflow_err === m_ovf);
        for (int l = 0; l < c_an; l++)
          if (ev[l] && (v_alloc_id[l] !== eid[l])) ok = 1'b0;
        n_tests++;
        if (!ok) begin
          n_fail++;
          $display("FAIL rand cyc%0d: vld %b exp %b, cnt %0d exp %0d, ovf %b exp %b, ids %h exp %h",
                   c, v_alloc_vld, ev, free_cnt, freeq.size(), overflow_err, m_ovf,
                   v_alloc_id, eid);
        end
      end

      if (do_rst) begin
        model_reset();
      end else begin
        fired.delete();
        for (int l = 0; l < c_an; l++)
          if (!zr[l] && ev[l] && rd[l]) fired.push_back(int'(eid[l]));
        if (fired.size() > 0) begin
          ok = 1'b1;
          foreach (fired[f]) begin
            foreach (outq[o]) if (outq[o] == fired[f]) ok = 1'b0;
          end
          n_tests++;
          if (!ok) begin
            n_fail++;
            $display("FAIL rand cyc%0d dup: allocated ID already outstanding", c);
          end
        end
        for (int f = 0; f < fired.size(); f++) begin
          void'(freeq.pop_front());
          outq.push_back(fired[f]);
        end
        ovf_n = 1'b0;
        for (int ch = 0; ch < c_rn; ch++) begin
          if (en[ch] && rid[ch] != '0) begin
            if (freeq.size() < c_depth) freeq.push_back(int'(rid[ch]));
            else ovf_n = 1'b1;
          end
        end
        m_ovf = ovf_n;
      end
    end

    @(negedge clk);
    rst_n        = 1'b1;
    v_alloc_rdy  = '0;
    v_release_en = '0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
